// File: rtl/sarlock_pkg.sv
// Shared types and helpers for the SARLock sequential lock.
// Loader states and the bit-counter width helper used by the key loader.
package sarlock_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StLoad,
    StFull
  } load_state_e;

  // Width that can hold the saturating shift count 0..key_w inclusive.
  function automatic int unsigned cnt_width(input int unsigned key_w);
    return $clog2(key_w + 1);
  endfunction

endpackage

// File: rtl/sarlock_key_loader.sv
// Serial key loader: staging shift register, saturating bit counter, loader FSM
// and commit handling. Exports the active key and its sticky valid flag.
module sarlock_key_loader
  import sarlock_pkg::*;
#(
  parameter int unsigned KEY_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             key_sdi,
  input  logic             key_shift,
  input  logic             key_commit,
  output logic [KEY_W-1:0] key,
  output logic             key_valid,
  output logic             commit_err
);

  localparam int unsigned CW = cnt_width(KEY_W);
  localparam logic [CW-1:0] CntFull = CW'(KEY_W);

  load_state_e      state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [KEY_W-1:0] stage_q, stage_d;
  logic [KEY_W-1:0] key_q, key_d;
  logic             key_valid_q, key_valid_d;
  logic             commit_err_q, commit_err_d;

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    stage_d      = stage_q;
    key_d        = key_q;
    key_valid_d  = key_valid_q;
    commit_err_d = 1'b0;

    if (key_commit) begin
      // A commit only succeeds from a complete load with no shift in flight.
      if (state_q == StFull && !key_shift) begin
        key_d       = stage_q;
        key_valid_d = 1'b1;
      end else begin
        commit_err_d = 1'b1;
      end
      stage_d = '0;
      cnt_d   = '0;
      state_d = StIdle;
    end else if (key_shift) begin
      stage_d = {stage_q[KEY_W-2:0], key_sdi};
      cnt_d   = (cnt_q == CntFull) ? cnt_q : cnt_q + 1'b1;
      state_d = (cnt_d == CntFull) ? StFull : StLoad;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= StIdle;
      cnt_q        <= '0;
      stage_q      <= '0;
      key_q        <= '0;
      key_valid_q  <= 1'b0;
      commit_err_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      stage_q      <= stage_d;
      key_q        <= key_d;
      key_valid_q  <= key_valid_d;
      commit_err_q <= commit_err_d;
    end
  end

  assign key        = key_q;
  assign key_valid  = key_valid_q;
  assign commit_err = commit_err_q;

endmodule

// File: rtl/sarlock_seq_lock.sv
// SARLock point-function output lock with serially loaded key: flips the
// selected outputs for the single pattern equal to a wrong active key.
module sarlock_seq_lock
  import sarlock_pkg::*;
#(
  parameter int unsigned          KEY_W       = 32,
  parameter int unsigned          NUM_OUT     = 1,
  parameter logic [NUM_OUT-1:0]   FLIP_SEL    = '1,
  parameter logic [KEY_W-1:0]     CORRECT_KEY = '0,
  parameter int unsigned          CNT_W       = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               key_sdi,
  input  logic               key_shift,
  input  logic               key_commit,
  input  logic [KEY_W-1:0]   in_pattern,
  input  logic               in_valid,
  input  logic [NUM_OUT-1:0] enc_out,
  output logic [NUM_OUT-1:0] out,
  output logic               out_valid,
  output logic               key_valid,
  output logic               commit_err,
  output logic [CNT_W-1:0]   flip_count
);

  localparam logic [CNT_W-1:0] CntMax = '1;

  logic [KEY_W-1:0]   active_key;
  logic               hit;
  logic [NUM_OUT-1:0] flip_mask;
  logic [NUM_OUT-1:0] out_q, out_d;
  logic               out_valid_q;
  logic [CNT_W-1:0]   flip_q, flip_d;

  sarlock_key_loader #(
    .KEY_W(KEY_W)
  ) u_loader (
    .clk       (clk),
    .rst       (rst),
    .key_sdi   (key_sdi),
    .key_shift (key_shift),
    .key_commit(key_commit),
    .key       (active_key),
    .key_valid (key_valid),
    .commit_err(commit_err)
  );

  // Compare against the current key; a same-cycle commit takes effect next cycle.
  assign hit       = (in_pattern == active_key) && (active_key != CORRECT_KEY);
  assign flip_mask = {NUM_OUT{hit}} & FLIP_SEL;

  always_comb begin
    out_d  = out_q;
    flip_d = flip_q;
    if (in_valid) begin
      out_d = enc_out ^ flip_mask;
      if (|flip_mask && flip_q != CntMax) begin
        flip_d = flip_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_q       <= '0;
      out_valid_q <= 1'b0;
      flip_q      <= '0;
    end else begin
      out_q       <= out_d;
      out_valid_q <= in_valid;
      flip_q      <= flip_d;
    end
  end

  assign out        = out_q;
  assign out_valid  = out_valid_q;
  assign flip_count = flip_q;

endmodule

// File: tb/tb_sarlock_seq_lock.sv
// Self-checking bench for sarlock_seq_lock: directed scenarios plus a random
// run against a queue-based behavioural model of the lock.
module tb_sarlock_seq_lock;

  localparam int unsigned KW = 4;
  localparam logic [1:0]  FS = 2'b01;
  localparam logic [3:0]  CK = 4'b1010;

  logic       clk = 1'b0;
  logic       rst, key_sdi, key_shift, key_commit, in_valid;
  logic [3:0] in_pattern;
  logic [1:0] enc_out;
  logic [1:0] out;
  logic       out_valid, key_valid, commit_err;
  logic [2:0] flip_count;

  int n_vec = 0;
  int n_err = 0;

  // Model state: key bits shifted since last commit/reset, plus expected outputs.
  bit         m_bits[$];
  logic [3:0] m_key;
  logic       m_kv, m_err, m_outv;
  logic [1:0] m_out;
  logic [2:0] m_flip;

  always #5 clk = ~clk;

  sarlock_seq_lock #(
    .KEY_W      (KW),
    .NUM_OUT    (2),
    .FLIP_SEL   (FS),
    .CORRECT_KEY(CK),
    .CNT_W      (3)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .key_sdi   (key_sdi),
    .key_shift (key_shift),
    .key_commit(key_commit),
    .in_pattern(in_pattern),
    .in_valid  (in_valid),
    .enc_out   (enc_out),
    .out       (out),
    .out_valid (out_valid),
    .key_valid (key_valid),
    .commit_err(commit_err),
    .flip_count(flip_count)
  );

  // Apply one cycle of inputs, advance the model, sample 1 time unit after the edge.
  task automatic tick(input logic r, input logic sh, input logic sdi, input logic cm,
                      input logic iv, input logic [3:0] pat, input logic [1:0] enc);
    logic hit;
    int   n;
    rst = r; key_shift = sh; key_sdi = sdi; key_commit = cm;
    in_valid = iv; in_pattern = pat; enc_out = enc;
    @(posedge clk);
    if (r) begin
      m_bits.delete();
      m_key = '0; m_kv = 0; m_err = 0; m_out = '0; m_outv = 0; m_flip = '0;
    end else begin
      if (iv) begin
        hit   = (pat == m_key) && (m_key != CK);
        m_out = enc ^ (hit ? FS : 2'b00);
        if (hit && FS != 2'b00 && m_flip != 3'd7) m_flip = m_flip + 3'd1;
      end
      m_outv = iv;
      m_err  = 0;
      if (cm) begin
        n = m_bits.size();
        if (!sh && n >= KW) begin
          for (int j = 0; j < KW; j++) m_key[KW-1-j] = m_bits[n-KW+j];
          m_kv = 1;
        end else begin
          m_err = 1;
        end
        m_bits.delete();
      end else if (sh) begin
        m_bits.push_back(sdi);
      end
    end
    #1;
  endtask

  task automatic idle();
    tick(0, 0, 0, 0, 0, 4'h0, 2'b00);
  endtask

  task automatic shift_bits(input logic [3:0] v, input int n);
    for (int i = 0; i < n; i++) tick(0, 1, v[3-i], 0, 0, 4'h0, 2'b00);
  endtask

  task automatic commit();
    tick(0, 0, 0, 1, 0, 4'h0, 2'b00);
  endtask

  task automatic test_reset();
    tick(1, 0, 0, 0, 0, 4'h0, 2'b00);
    tick(1, 0, 0, 0, 0, 4'h0, 2'b00);
    n_vec++;
    if ({out, out_valid, key_valid, commit_err, flip_count} !== 8'b0) begin
      n_err++;
      $display("FAIL reset: got out=%b ov=%b kv=%b err=%b cnt=%0d, want all zero",
               out, out_valid, key_valid, commit_err, flip_count);
    end
  endtask

  task automatic test_unloaded();
    tick(0, 0, 0, 0, 1, 4'b0000, 2'b11);
    n_vec++;
    if (out !== 2'b10 || out_valid !== 1'b1 || flip_count !== 3'd1) begin
      n_err++;
      $display("FAIL unloaded_hit: got out=%b ov=%b cnt=%0d, want out=10 ov=1 cnt=1",
               out, out_valid, flip_count);
    end
    idle();
    n_vec++;
    if (out_valid !== 1'b0 || out !== 2'b10) begin
      n_err++;
      $display("FAIL idle_hold: got out=%b ov=%b, want out=10 ov=0", out, out_valid);
    end
  endtask

  task automatic test_correct_key();
    logic [2:0] cnt0;
    logic [1:0] enc;
    shift_bits(4'b1010, 4);
    commit();
    n_vec++;
    if (key_valid !== 1'b1 || commit_err !== 1'b0) begin
      n_err++;
      $display("FAIL correct_commit: got kv=%b err=%b, want kv=1 err=0", key_valid, commit_err);
    end
    cnt0 = m_flip;
    for (int p = 0; p < 16; p++) begin
      enc = 2'($urandom);
      tick(0, 0, 0, 0, 1, 4'(p), enc);
      n_vec++;
      if (out !== enc || out_valid !== 1'b1 || flip_count !== cnt0) begin
        n_err++;
        $display("FAIL correct_sweep p=%0d: got out=%b ov=%b cnt=%0d, want out=%b ov=1 cnt=%0d",
                 p, out, out_valid, flip_count, enc, cnt0);
      end
    end
  endtask

  task automatic test_wrong_key();
    shift_bits(4'b0110, 4);
    commit();
    tick(0, 0, 0, 0, 1, 4'b0110, 2'b00);
    n_vec++;
    if (out !== 2'b01) begin
      n_err++;
      $display("FAIL wrong_key_hit: got out=%b, want 01", out);
    end
    tick(0, 0, 0, 0, 1, 4'b0111, 2'b00);
    n_vec++;
    if (out !== 2'b00) begin
      n_err++;
      $display("FAIL wrong_key_miss: got out=%b, want 00", out);
    end
  endtask

  task automatic test_bad_commit();
    shift_bits(4'b1110, 3);
    commit();
    n_vec++;
    if (commit_err !== 1'b1 || key_valid !== 1'b1) begin
      n_err++;
      $display("FAIL short_commit: got err=%b kv=%b, want err=1 kv=1", commit_err, key_valid);
    end
    idle();
    n_vec++;
    if (commit_err !== 1'b0) begin
      n_err++;
      $display("FAIL err_pulse_width: got err=%b, want 0", commit_err);
    end
    tick(0, 0, 0, 0, 1, 4'b0110, 2'b00);
    n_vec++;
    if (out !== 2'b01) begin
      n_err++;
      $display("FAIL key_kept: got out=%b, want 01", out);
    end
    shift_bits(4'b1111, 3);
    tick(0, 1, 1, 1, 0, 4'h0, 2'b00);
    n_vec++;
    if (commit_err !== 1'b1) begin
      n_err++;
      $display("FAIL shift_commit_clash: got err=%b, want 1", commit_err);
    end
    tick(0, 0, 0, 0, 1, 4'b0110, 2'b10);
    n_vec++;
    if (out !== 2'b11) begin
      n_err++;
      $display("FAIL key_kept2: got out=%b, want 11", out);
    end
  endtask

  task automatic test_saturate();
    logic [2:0] want;
    tick(1, 0, 0, 0, 0, 4'h0, 2'b00);
    for (int k = 1; k <= 9; k++) begin
      tick(0, 0, 0, 0, 1, 4'b0000, 2'b00);
      want = (k > 7) ? 3'd7 : 3'(k);
      n_vec++;
      if (flip_count !== want || out !== 2'b01) begin
        n_err++;
        $display("FAIL saturate k=%0d: got cnt=%0d out=%b, want cnt=%0d out=01",
                 k, flip_count, out, want);
      end
    end
  endtask

  task automatic test_same_cycle_commit();
    tick(1, 0, 0, 0, 0, 4'h0, 2'b00);
    shift_bits(4'b0110, 4);
    tick(0, 0, 0, 1, 1, 4'b0000, 2'b00);
    n_vec++;
    if (out !== 2'b01 || key_valid !== 1'b1) begin
      n_err++;
      $display("FAIL same_cycle_old_key: got out=%b kv=%b, want out=01 kv=1", out, key_valid);
    end
    tick(0, 0, 0, 0, 1, 4'b0000, 2'b00);
    n_vec++;
    if (out !== 2'b00) begin
      n_err++;
      $display("FAIL same_cycle_new_key_miss: got out=%b, want 00", out);
    end
    tick(0, 0, 0, 0, 1, 4'b0110, 2'b00);
    n_vec++;
    if (out !== 2'b01 || flip_count !== 3'd2) begin
      n_err++;
      $display("FAIL same_cycle_new_key_hit: got out=%b cnt=%0d, want out=01 cnt=2",
               out, flip_count);
    end
  endtask

  task automatic test_rst_midload();
    shift_bits(4'b1100, 2);
    tick(1, 1, 1, 1, 1, 4'b0110, 2'b11);
    n_vec++;
    if ({out, out_valid, key_valid, commit_err, flip_count} !== 8'b0) begin
      n_err++;
      $display("FAIL rst_midload: got out=%b ov=%b kv=%b err=%b cnt=%0d, want all zero",
               out, out_valid, key_valid, commit_err, flip_count);
    end
    shift_bits(4'b0000, 2);
    commit();
    n_vec++;
    if (commit_err !== 1'b1 || key_valid !== 1'b0) begin
      n_err++;
      $display("FAIL partial_discarded: got err=%b kv=%b, want err=1 kv=0", commit_err, key_valid);
    end
    tick(0, 0, 0, 0, 1, 4'b0000, 2'b00);
    n_vec++;
    if (out !== 2'b01) begin
      n_err++;
      $display("FAIL key_cleared: got out=%b, want 01", out);
    end
  endtask

  task automatic test_random();
    logic [3:0] pat;
    logic       r, sh, cm;
    for (int i = 0; i < 400; i++) begin
      r   = ($urandom_range(0, 49) == 0);
      sh  = $urandom_range(0, 1) == 1;
      cm  = ($urandom_range(0, 6) == 0);
      pat = ($urandom_range(0, 1) == 1) ? m_key : 4'($urandom);
      tick(r, sh, 1'($urandom), cm, 1'($urandom), pat, 2'($urandom));
      n_vec++;
      if ({out, out_valid, key_valid, commit_err, flip_count} !==
          {m_out, m_outv, m_kv, m_err, m_flip}) begin
        n_err++;
        $display("FAIL random i=%0d: got out=%b ov=%b kv=%b err=%b cnt=%0d, want out=%b ov=%b kv=%b err=%b cnt=%0d",
                 i, out, out_valid, key_valid, commit_err, flip_count,
                 m_out, m_outv, m_kv, m_err, m_flip);
      end
    end
  endtask

  initial begin
    rst = 1; key_sdi = 0; key_shift = 0; key_commit = 0;
    in_valid = 0; in_pattern = '0; enc_out = '0;
    test_reset();
    test_unloaded();
    test_correct_key();
    test_wrong_key();
    test_bad_commit();
    test_saturate();
    test_same_cycle_commit();
    test_rst_midload();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
